// File: rtl/hpi_responder.sv
// HPI chip-side responder: DATA/MAILBOX/ADDRESS/STATUS registers, a pointer-addressed
// word RAM and a two-way mailbox, answering cycles issued by hpi_io_intf.
module hpi_responder #(
  parameter int RAM_AW = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  inout  wire  [15:0]       OTG_DATA,
  input  logic [1:0]        OTG_ADDR,
  input  logic              OTG_CS_N,
  input  logic              OTG_RD_N,
  input  logic              OTG_WR_N,
  input  logic              OTG_RST_N,
  output logic              OTG_INT,
  input  logic              mbx_out_wr,
  input  logic [15:0]       mbx_out_data,
  output logic [15:0]       mbx_in_data,
  output logic              mbx_in_valid,
  input  logic              mbx_in_ack,
  input  logic [RAM_AW-1:0] loc_addr,
  output logic [15:0]       loc_rdata
);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic              wr_act, rd_act;
  logic              wr_q, rd_q;
  logic              wr_start, rd_start;
  logic [15:0]       ptr, ptr_inc;
  logic [RAM_AW-1:0] ptr_idx;
  logic [15:0]       rd_latch;
  logic [15:0]       mbx_out_q;
  logic              mbx_out_full;
  logic              ovf;
  logic              host_mem_wr, host_mem_rd, host_mbx_wr, host_mbx_rd, host_ptr_wr;
  logic [15:0]       status_word;
  logic              drive_en;

  logic [15:0] mem [2**RAM_AW];

  // Writing wins when both strobes are low; a held strobe acts only on its first cycle.
  assign wr_act   = !OTG_CS_N && !OTG_WR_N && OTG_RST_N;
  assign rd_act   = !OTG_CS_N && !OTG_RD_N && OTG_WR_N && OTG_RST_N;
  assign wr_start = wr_act && !wr_q;
  assign rd_start = rd_act && !rd_q;

  assign ptr_idx = ptr[RAM_AW:1];
  assign ptr_inc = ptr + 16'd2;

  assign host_mem_wr = wr_start && (OTG_ADDR == REG_DATA);
  assign host_mem_rd = rd_start && (OTG_ADDR == REG_DATA);
  assign host_mbx_wr = wr_start && (OTG_ADDR == REG_MBX);
  assign host_mbx_rd = rd_start && (OTG_ADDR == REG_MBX);
  assign host_ptr_wr = wr_start && (OTG_ADDR == REG_ADDR);

  assign status_word = {13'b0, ovf, mbx_in_valid, mbx_out_full};

  // Reset also releases the bus so an abandoned read never keeps driving it.
  assign drive_en = rd_act && !Reset;
  assign OTG_DATA = drive_en ? rd_latch : {16{1'bz}};
  assign OTG_INT  = mbx_out_full;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_act;
      rd_q <= rd_act;
    end
  end

  // Mailbox handshake: *_valid/*_full is set by the producer's write and held until the
  // consumer's read or ack clears it; a producer write in the same cycle as the clear
  // wins, and a host write landing on an un-acked message sets the sticky ovf.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr          <= 16'h0000;
      rd_latch     <= 16'h0000;
      mbx_in_data  <= 16'h0000;
      mbx_out_q    <= 16'h0000;
      mbx_out_full <= 1'b0;
      mbx_in_valid <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (mbx_out_wr)  mbx_out_q   <= mbx_out_data;
      if (host_mbx_wr) mbx_in_data <= OTG_DATA;

      if (!OTG_RST_N) begin
        ptr          <= 16'h0000;
        rd_latch     <= 16'h0000;
        mbx_out_full <= 1'b0;
        mbx_in_valid <= 1'b0;
        ovf          <= 1'b0;
      end else begin
        if (host_ptr_wr)
          ptr <= OTG_DATA;
        else if (host_mem_wr || host_mem_rd)
          ptr <= ptr_inc;

        if (mbx_out_wr)
          mbx_out_full <= 1'b1;
        else if (host_mbx_rd)
          mbx_out_full <= 1'b0;

        if (host_mbx_wr) begin
          mbx_in_valid <= 1'b1;
          if (mbx_in_valid && !mbx_in_ack) ovf <= 1'b1;
        end else if (mbx_in_ack) begin
          mbx_in_valid <= 1'b0;
        end

        if (rd_start) begin
          case (OTG_ADDR)
            REG_DATA: rd_latch <= mem[ptr_idx];
            REG_MBX:  rd_latch <= mbx_out_q;
            REG_ADDR: rd_latch <= ptr;
            REG_STAT: rd_latch <= status_word;
            default:  rd_latch <= 16'h0000;
          endcase
        end
      end
    end
  end

  // RAM has no reset; contents survive both Reset and the host soft reset.
  always_ff @(posedge Clk) begin
    if (host_mem_wr) mem[ptr_idx] <= OTG_DATA;
    loc_rdata <= mem[loc_addr];
  end

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: host register cycles, mailbox traffic, pointer wrap,
// soft reset and asynchronous reset, each step checked against hand-computed values.
module tb_hpi_responder;

  logic        Clk;
  logic        Reset;
  wire  [15:0] OTG_DATA;
  logic [1:0]  OTG_ADDR;
  logic        OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N;
  logic        OTG_INT;
  logic        mbx_out_wr;
  logic [15:0] mbx_out_data;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [7:0]  loc_addr;
  logic [15:0] loc_rdata;

  logic        tb_drv;
  logic [15:0] tb_data;
  logic [15:0] rd_val;

  int checks = 0;
  int errors = 0;

  assign OTG_DATA = tb_drv ? tb_data : {16{1'bz}};

  hpi_responder #(.RAM_AW(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_DATA     (OTG_DATA),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_RST_N    (OTG_RST_N),
    .OTG_INT      (OTG_INT),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_data (mbx_out_data),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .loc_addr     (loc_addr),
    .loc_rdata    (loc_rdata)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drivers: each starts and ends 1ns after a rising edge.
  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    OTG_ADDR = a; tb_data = d; tb_drv = 1'b1;
    OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    @(posedge Clk); #1;
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; tb_drv = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    OTG_ADDR = a;
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    @(posedge Clk); #1;
    d = OTG_DATA;
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic local_post(input logic [15:0] d);
    mbx_out_wr = 1'b1; mbx_out_data = d;
    @(posedge Clk); #1;
    mbx_out_wr = 1'b0;
  endtask

  task automatic local_ack();
    mbx_in_ack = 1'b1;
    @(posedge Clk); #1;
    mbx_in_ack = 1'b0;
  endtask

  task automatic local_peek(input logic [7:0] a, output logic [15:0] d);
    loc_addr = a;
    @(posedge Clk); #1;
    d = loc_rdata;
  endtask

  // Bench drives zeros onto the bus: reads back zero only if the DUT has let go.
  task automatic check_released(input string tag);
    tb_data = 16'h0000; tb_drv = 1'b1;
    #1;
    chk(tag, OTG_DATA, 16'h0000);
    tb_drv = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    OTG_ADDR = 2'd0; OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1; OTG_RST_N = 1'b1;
    mbx_out_wr = 1'b0; mbx_out_data = 16'h0000; mbx_in_ack = 1'b0; loc_addr = 8'h00;
    tb_drv = 1'b0; tb_data = 16'h0000;
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_int", {15'b0, OTG_INT}, 16'h0000);
    chk("rst_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
    chk("rst_in_data", mbx_in_data, 16'h0000);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_released("rst_bus_released");
    host_read(2'd3, rd_val); chk("rst_status", rd_val, 16'h0000);

    // Pointer-addressed RAM writes and reads
    host_write(2'd2, 16'h0010);
    host_write(2'd0, 16'hAAAA);
    host_write(2'd0, 16'hBBBB);
    host_write(2'd2, 16'h0010);
    host_read(2'd0, rd_val); chk("data_rd0", rd_val, 16'hAAAA);
    host_read(2'd0, rd_val); chk("data_rd1", rd_val, 16'hBBBB);
    host_read(2'd2, rd_val); chk("ptr_after_rd", rd_val, 16'h0014);
    local_peek(8'h08, rd_val); chk("loc_08", rd_val, 16'hAAAA);
    local_peek(8'h09, rd_val); chk("loc_09", rd_val, 16'hBBBB);

    // Held write strobe acts exactly once
    host_write(2'd2, 16'h0022);
    host_write(2'd0, 16'hCCCC);
    host_write(2'd2, 16'h0020);
    OTG_ADDR = 2'd0; tb_data = 16'h1111; tb_drv = 1'b1;
    OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; tb_drv = 1'b0;
    @(posedge Clk); #1;
    host_read(2'd2, rd_val); chk("held_wr_ptr", rd_val, 16'h0022);
    local_peek(8'h10, rd_val); chk("held_wr_loc10", rd_val, 16'h1111);
    local_peek(8'h11, rd_val); chk("held_wr_loc11", rd_val, 16'hCCCC);

    // Outbound mailbox and interrupt
    local_post(16'h1234);
    chk("int_set", {15'b0, OTG_INT}, 16'h0001);
    host_read(2'd3, rd_val); chk("status_out_full", rd_val, 16'h0001);
    host_read(2'd1, rd_val); chk("mbx_rd", rd_val, 16'h1234);
    chk("int_clear", {15'b0, OTG_INT}, 16'h0000);
    host_read(2'd3, rd_val); chk("status_after_mbx_rd", rd_val, 16'h0000);

    // Inbound mailbox with overflow
    host_write(2'd1, 16'h0055);
    chk("in_valid_set", {15'b0, mbx_in_valid}, 16'h0001);
    chk("in_data_55", mbx_in_data, 16'h0055);
    host_write(2'd1, 16'h0066);
    chk("in_data_66", mbx_in_data, 16'h0066);
    host_read(2'd3, rd_val); chk("status_ovf", rd_val, 16'h0006);
    local_ack();
    host_read(2'd3, rd_val); chk("status_after_ack", rd_val, 16'h0004);

    // Local post coinciding with host MAILBOX read start
    local_post(16'hAAA1);
    OTG_ADDR = 2'd1; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    mbx_out_wr = 1'b1; mbx_out_data = 16'hBBB2;
    @(posedge Clk); #1;
    mbx_out_wr = 1'b0;
    chk("coinc_rd_old", OTG_DATA, 16'hAAA1);
    chk("coinc_int_held", {15'b0, OTG_INT}, 16'h0001);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    @(posedge Clk); #1;
    host_read(2'd1, rd_val); chk("coinc_rd_new", rd_val, 16'hBBB2);
    chk("coinc_int_clear", {15'b0, OTG_INT}, 16'h0000);

    // Pointer wrap
    host_write(2'd2, 16'hFFFE);
    host_write(2'd0, 16'h7777);
    host_read(2'd2, rd_val); chk("ptr_wrap", rd_val, 16'h0000);
    local_peek(8'hFF, rd_val); chk("loc_ff", rd_val, 16'h7777);

    // Host soft reset
    local_post(16'h4321);
    host_write(2'd2, 16'h0020);
    chk("srst_int_before", {15'b0, OTG_INT}, 16'h0001);
    host_read(2'd3, rd_val); chk("srst_status_before", rd_val, 16'h0005);
    OTG_ADDR = 2'd3; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_RST_N = 1'b0;
    check_released("srst_bus_released");
    @(posedge Clk); #1;
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_RST_N = 1'b1;
    chk("srst_int", {15'b0, OTG_INT}, 16'h0000);
    host_read(2'd3, rd_val); chk("srst_status", rd_val, 16'h0000);
    host_read(2'd2, rd_val); chk("srst_ptr", rd_val, 16'h0000);
    local_peek(8'h10, rd_val); chk("srst_ram_kept", rd_val, 16'h1111);
    host_read(2'd1, rd_val); chk("srst_msg_kept", rd_val, 16'h4321);

    // Asynchronous reset in the middle of a read, then a write held across release
    local_post(16'h5A5A);
    OTG_ADDR = 2'd3; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    @(posedge Clk); #1;
    chk("pre_reset_rd", OTG_DATA, 16'h0001);
    Reset = 1'b1;
    #1;
    chk("areset_int", {15'b0, OTG_INT}, 16'h0000);
    check_released("areset_bus_released");
    OTG_RD_N = 1'b1; OTG_ADDR = 2'd2; tb_data = 16'h0040; tb_drv = 1'b1; OTG_WR_N = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; tb_drv = 1'b0;
    @(posedge Clk); #1;
    host_read(2'd2, rd_val); chk("held_wr_after_reset", rd_val, 16'h0040);
    chk("areset_in_data", mbx_in_data, 16'h0000);
    host_read(2'd3, rd_val); chk("areset_status", rd_val, 16'h0000);

    // Ack coinciding with a host MAILBOX write start
    host_write(2'd1, 16'h0077);
    OTG_ADDR = 2'd1; tb_data = 16'h0088; tb_drv = 1'b1;
    OTG_CS_N = 1'b0; OTG_WR_N = 1'b0; mbx_in_ack = 1'b1;
    @(posedge Clk); #1;
    mbx_in_ack = 1'b0; OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; tb_drv = 1'b0;
    @(posedge Clk); #1;
    chk("coinc_ack_data", mbx_in_data, 16'h0088);
    chk("coinc_ack_valid", {15'b0, mbx_in_valid}, 16'h0001);
    host_read(2'd3, rd_val); chk("coinc_ack_status", rd_val, 16'h0002);
    local_ack();
    chk("final_ack_valid", {15'b0, mbx_in_valid}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
# hpi_responder

Synthesizable responder for the CY7C67200 host-port interface: the chip-side stand-in that answers the HPI cycles issued by `hpi_io_intf`. It provides the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS), a small word RAM reached through an auto-incrementing pointer, and a two-way mailbox with interrupt. It lets the keycode path and NIOS HPI software be brought up on the board or in simulation without the real EZ-OTG chip.

## Interface
- `RAM_AW`, 8: word-address width of the internal RAM (2^RAM_AW 16-bit words).
- `Clk`  in  1  system clock (CLOCK_50 domain, same as `hpi_io_intf`).
- `Reset`  in  1  asynchronous, active-high reset.
- `OTG_DATA`  inout  16  HPI data bus; driven only during a host read.
- `OTG_ADDR`  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- `OTG_CS_N`, `OTG_RD_N`, `OTG_WR_N`  in  1 each  active-low chip select / read / write strobes.
- `OTG_RST_N`  in  1  active-low HPI soft reset from the host.
- `OTG_INT`  out  1  high while a message for the host is pending.
- `mbx_out_wr`  in  1  local side posts `mbx_out_data` to the host (1-cycle pulse).
- `mbx_out_data`  in  16  message to host.
- `mbx_in_data`  out  16  last message written by the host.
- `mbx_in_valid`  out  1  host message pending for local side.
- `mbx_in_ack`  in  1  local side consumed `mbx_in_data` (1-cycle pulse).
- `loc_addr`  in  RAM_AW  local read port word address.
- `loc_rdata`  out  16  `mem[loc_addr]`, one-cycle latency.

## Operation
- Strobe decode, per Clk: `wr_act = !CS_N && !WR_N && RST_N`; `rd_act = !CS_N && !RD_N && WR_N && RST_N` (WR_N and RD_N both low counts as write only). Registered copies give `wr_start`/`rd_start` = first cycle of each active strobe; a held strobe acts exactly once.
- `ptr`: 16-bit byte address. RAM index = `ptr[RAM_AW:1]`; bit 0 ignored; higher bits alias.
- Write start, by `OTG_ADDR`:
  - 0: `mem[ptr] <= OTG_DATA`; `ptr <= ptr + 2`.
  - 1: `mbx_in_data <= OTG_DATA`; `mbx_in_valid <= 1`; if already valid, set sticky `ovf`.
  - 2: `ptr <= OTG_DATA`.
  - 3: ignored.
- Read start: `rd_latch` loaded by `OTG_ADDR`:
  - 0: `mem[ptr]`; `ptr <= ptr + 2`.
  - 1: `mbx_out_q`; clears `mbx_out_full`.
  - 2: `ptr`.
  - 3: `{13'b0, ovf, mbx_in_valid, mbx_out_full}`.
- `OTG_DATA = rd_act ? rd_latch : 'z`.
- Local mailbox:
  - `mbx_out_wr` loads `mbx_out_q` and sets `mbx_out_full`.
  - `mbx_in_ack` clears `mbx_in_valid`.
  - `OTG_INT = mbx_out_full`.
- Simultaneous events:
  - `mbx_out_wr` with a host MAILBOX read start: the host receives the old value, the new value is stored, `mbx_out_full` stays 1.
  - `mbx_in_ack` with a host MAILBOX write start: `mbx_in_valid` stays 1 and `ovf` is not set.
- `ptr` wraps 0xFFFE -> 0x0000.
- `OTG_RST_N` low:
  - Synchronously clears `ptr`, `mbx_out_full`, `mbx_in_valid`, `ovf`, `rd_latch`.
  - Suppresses all strobes and releases the bus.
  - RAM and message data are kept.
- `Reset`:
  - `ptr`=0, `rd_latch`=0, `mbx_in_data`=0, `mbx_out_q`=0, all flags 0, strobe history = inactive.
  - Therefore `OTG_INT`=0, `mbx_in_valid`=0, `OTG_DATA`=Z.
  - RAM is not reset; `loc_rdata` is undefined until the first clock.

## Timing
- Write commits at the Clk edge ending the `wr_start` cycle; data and address must be stable in that cycle.
- Read data is valid from the cycle after `rd_start` until the strobe ends. Bus released combinationally with the strobe.
- Pointer increment is visible to a back-to-back access one cycle after the strobe.
- Minimum strobe: 1 cycle active, 1 cycle inactive between accesses.
- `OTG_INT` rises 1 cycle after `mbx_out_wr`, falls 1 cycle after a MAILBOX `rd_start`.
- `mbx_in_valid` rises 1 cycle after a MAILBOX `wr_start`.
- An access in progress when `Reset` asserts is abandoned. After release, a strobe still held low produces a new `wr_start`/`rd_start` on the first clock.

## Test plan
- Write ADDRESS=0x0010, DATA 0xAAAA, 0xBBBB, then ADDRESS=0x0010 and two DATA reads -> 0xAAAA, 0xBBBB; ADDRESS read -> 0x0014; `loc_addr`=8 gives 0xAAAA.
- Hold WR_N low 5 cycles on DATA -> single RAM write, `ptr` advances by 2 only.
- `mbx_out_wr` with 0x1234 -> `OTG_INT`=1, STATUS=0x0001; MAILBOX read -> 0x1234, then `OTG_INT`=0, STATUS=0x0000.
- Host MAILBOX writes 0x0055 then 0x0066 without ack -> `mbx_in_data`=0x0066, STATUS=0x0006; `mbx_in_ack` -> STATUS=0x0004.
- ADDRESS=0xFFFE, DATA write 0x7777 -> `ptr`=0x0000; `mem[0xFF]`=0x7777 with RAM_AW=8.
- `OTG_RST_N` low 1 cycle with `OTG_INT`=1 and `ptr`=0x20 -> `OTG_INT`=0, `ptr`=0, RAM contents unchanged; async `Reset` mid-read -> `OTG_DATA`=Z immediately.
